// File: rtl/divclk_checker.sv
// divclk_checker: watches div2/div4/div8 from the local divider.
// Per-channel period, duty and phase checks with lock and sticky error.
module divclk_checker #(
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear_err,
  input  logic [2:0]         div_in,
  output logic [2:0]         locked,
  output logic [2:0]         err,
  output logic [5:0]         err_cause,
  output logic [3*CNT_W-1:0] period,
  output logic               all_locked
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    TRACK,
    LOCK,
    ERR
  } state_t;

  logic [2:0] div_q;
  logic [2:0] rise;
  logic [2:0] fall;

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_in;
  end

  assign rise = div_in & ~div_q;
  assign fall = ~div_in & div_q;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam logic [CNT_W-1:0] P    = CNT_W'(2 << i);
    localparam logic [CNT_W-1:0] H    = CNT_W'(1 << i);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [3:0]       LCK  = 4'(LOCK_CNT);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [3:0]       good_q, good_d;
    logic [1:0]       cause_q, cause_d;
    logic [1:0]       mis;
    logic             ph_bad;

    // div4/div8 may only move when the next-faster channel falls
    if (i == 0) begin : g_ph0
      assign ph_bad = 1'b0;
    end else begin : g_phn
      assign ph_bad = (rise[i] | fall[i]) & ~fall[i-1];
    end

    always_comb begin
      mis = 2'd0;
      if (ph_bad)
        mis = 2'd3;
      else if (rise[i] && cnt_q != P)
        mis = 2'd1;
      else if (fall[i] && cnt_q != H)
        mis = 2'd2;
      else if (div_in[i] && div_q[i] && cnt_q >= H)
        mis = 2'd2;
      else if (!div_in[i] && !div_q[i] && cnt_q >= P)
        mis = 2'd1;
    end

    always_comb begin
      st_d    = st_q;
      good_d  = good_q;
      cause_d = cause_q;
      per_d   = per_q;
      if (rise[i])           cnt_d = ONE;
      else if (cnt_q == CMAX) cnt_d = cnt_q;
      else                   cnt_d = cnt_q + ONE;
      if (!enable) begin
        st_d    = IDLE;
        good_d  = '0;
        cause_d = '0;
        cnt_d   = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            st_d  = SYNC;
            cnt_d = '0;
          end
          SYNC: begin
            if (rise[i]) begin
              st_d   = TRACK;
              good_d = '0;
            end
          end
          TRACK, LOCK: begin
            if (rise[i]) per_d = cnt_q;
            if (mis != 2'd0) begin
              st_d    = ERR;
              cause_d = mis;
            end else if (st_q == TRACK && rise[i]) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LCK) st_d = LOCK;
            end
          end
          ERR: begin
            if (clear_err) begin
              st_d    = SYNC;
              cause_d = '0;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        per_q   <= '0;
        good_q  <= '0;
        cause_q <= '0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        good_q  <= good_d;
        cause_q <= cause_d;
      end
    end

    assign locked[i]                 = (st_q == LOCK);
    assign err[i]                    = (st_q == ERR);
    assign err_cause[2*i +: 2]       = cause_q;
    assign period[CNT_W*i +: CNT_W]  = per_q;
  end

  assign all_locked = &locked;

endmodule
